uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver; successor to the fixed 8-bit mid-bit-sampling receiver. Adds a 5–9 data-bit width, 1 or 2 stop bits, and 3-sample majority voting. It also adds false-start rejection, break detection, separate error flags and a valid/ready output handshake with overrun detection. Sits between the board-level rx pin and the byte consumer (FIFO / command parser).

Parameters:
DIV, 27, system clocks per oversample tick (50 MHz / (115200*16) ≈ 27); legal 2..4095
OS, 16, oversample ticks per bit; legal even values 8..32
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
rx_line  input  1  asynchronous serial input, idle high
rx_ready  input  1  consumer accepts rx_data when valid&&rx_ready
rx_data  output  DATA_BITS  received word, LSB = first bit on line
valid  output  1  rx_data holds an unconsumed word
busy  output  1  frame in progress
parity_err  output  1  parity mismatch on last completed frame
frame_err  output  1  stop bit sampled low on last completed frame
break_det  output  1  last frame was a break condition
overrun  output  1  frame completed while valid still high (sticky)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; synchroniser = 2'b11; counters 0.
- rx_line passes a 2-FF synchroniser (reset value 1). All decisions use the synchronised value `s`.
- Tick counter runs 0..DIV-1 only when state != IDLE. tick=1 in the cycle the counter equals DIV-1, then it wraps to 0. Counter is cleared in IDLE.
- Sample counter runs 0..OS-1 per bit and advances on tick. Samples are taken at counts OS/2-1, OS/2 and OS/2+1. The bit value is the majority of these 3, decided at count OS/2+1.
- States: IDLE, START, DATA, PARITY, STOP, BRK.
- IDLE: s==0 → START, with tick and sample counters at 0. busy=1 from the following cycle.
- START: majority==1 → false start, return to IDLE; no flags change, busy→0. Majority==0 → at sample count OS-1 go to DATA, bit index 0.
- DATA: store majority into rx_buf[bit index] (LSB first) and accumulate XOR. After DATA_BITS bits → PARITY if PARITY!=0, else STOP.
- PARITY: error if (data XOR ^ p) != (PARITY==1 ? 1 : 0).
- STOP: check STOP_BITS bits; any 0 majority → frame error.
- Completion at the mid-sample decision of the last stop bit, without waiting out the full bit. This allows back-to-back resync. Completion writes parity_err and frame_err.
- Break at completion: all data bits 0, parity bit (if any) 0, and any stop bit 0. Sets break_det=1, frame_err=1, valid unchanged → BRK.
- BRK: wait for s==1, then IDLE; busy stays 1 throughout BRK.
- Normal completion → IDLE, busy→0, break_det=0.
- Delivery on completion with frame_err=0 (parity_err may be 1):
  - If valid==0 or rx_ready==1 in that cycle: rx_data←rx_buf, valid←1.
  - Else: new word dropped, old rx_data kept, overrun←1.
- Frame_err frames are never delivered; rx_data is unchanged.
- Handshake: valid&&rx_ready clears valid next cycle unless a new word loads in the same cycle (valid stays 1, new data). That handshake also clears overrun.
- rx_ready is ignored while valid==0.
- Latency: valid rises 1 clk after the completion tick, about (1+DATA_BITS+P+STOP_BITS-0.5) bit times after the start edge, plus 2 clk of synchroniser delay.
- Glitches shorter than 2 of 3 votes at any sample point are rejected.

Test Plan:
- DIV=4, OS=16, 8N1, send 0xA5 with rx_ready=0 → valid=1, rx_data=0xA5, all flags 0, busy=0. valid holds until rx_ready=1, then drops next clk.
- Low pulse of 5 ticks on an idle line → busy rises then falls, no valid, flags unchanged. 1-tick low glitch at sample OS/2 of data bit 3 in 0xFF → rx_data=0xFF.
- PARITY=2, send 0x5A with parity bit 1 → valid=1, rx_data=0x5A, parity_err=1. Correct parity bit 0 → parity_err=0.
- 8N1, 0x3C with stop bit 0 → frame_err=1, valid stays 0. Line held low 20 bit times → break_det=1, busy=1 until line high, then busy=0; next 0x41 received cleanly, break_det=0.
- Back-to-back 0x11, 0x22 with rx_ready=0 → rx_data=0x11, overrun=1. Pulse rx_ready → valid=0, overrun=0.
- DATA_BITS=9, STOP_BITS=2, send 0x1A5 then second stop bit 0 → frame_err=1. rst_n=0 mid-frame of next word → all outputs 0 next clk. A following frame 0x0F0 is received correctly.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Receiver-to-consumer bundle: received word, status flags and the valid/ready handshake.
// The receiver drives everything except rx_ready; the consumer drives rx_ready only.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 valid;
    logic                 rx_ready;
    logic                 busy;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output rx_data, valid, busy, parity_err, frame_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, valid, busy, parity_err, frame_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-vote majority per bit, 5..9 data bits, optional parity,
// 1 or 2 stop bits, false-start rejection, break detection and overrun-flagged handshake.
module uart_rx_os #(
    parameter int DIV       = 27,
    parameter int OS        = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_line_i,
    uart_rx_os_if.master  rx_if
);
    localparam int TW = $clog2(DIV);
    localparam int SW = $clog2(OS);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_V0   = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] SAMP_V1   = SW'(OS / 2);
    localparam logic [SW-1:0] SAMP_DEC  = SW'(OS / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OS - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic want;
        want = (PARITY == 1) ? 1'b1 : 1'b0;
        return ((^d) ^ p) != want;
    endfunction

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]          samp_cnt_q, samp_cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [1:0]             vote_q, vote_d;
    logic [DATA_BITS-1:0]   rx_buf_q, rx_buf_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   pe_q, pe_d;
    logic                   fe_q, fe_d;
    logic                   brk_q, brk_d;
    logic                   ovr_q, ovr_d;

    logic s_s, tick_s, dec_s, bit_end_s, maj_s;
    logic complete_s, hs_s, fe_c_s, pe_c_s, brk_c_s;

    assign s_s       = sync_q[1];
    assign tick_s    = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
    assign dec_s     = tick_s && (samp_cnt_q == SAMP_DEC);
    assign bit_end_s = tick_s && (samp_cnt_q == SAMP_LAST);
    assign maj_s     = maj3(vote_q[0], vote_q[1], s_s);
    assign hs_s      = valid_q && rx_if.rx_ready;

    // The stop-bit decision completes the frame, so the last vote feeds the error terms directly.
    assign fe_c_s  = stop_err_q | ~maj_s;
    assign pe_c_s  = (PARITY != 0) ? parity_bad(rx_buf_q, par_bit_q) : 1'b0;
    assign brk_c_s = (rx_buf_q == '0) && ((PARITY == 0) || !par_bit_q) && fe_c_s;

    // Next-state, counters, bit assembly, completion and handshake.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        vote_d     = vote_q;
        rx_buf_d   = rx_buf_q;
        par_bit_d  = par_bit_q;
        stop_err_d = stop_err_q;
        rx_data_d  = rx_data_q;
        valid_d    = valid_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        brk_d      = brk_q;
        ovr_d      = ovr_q;
        complete_s = 1'b0;

        if (state_q == S_IDLE) begin
            tick_cnt_d = '0;
            samp_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
            samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            samp_cnt_d = samp_cnt_q;
        end

        if (tick_s && (samp_cnt_q == SAMP_V0)) begin
            vote_d[0] = s_s;
        end else if (tick_s && (samp_cnt_q == SAMP_V1)) begin
            vote_d[1] = s_s;
        end else begin
            vote_d = vote_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!s_s) begin
                    state_d    = S_START;
                    bit_idx_d  = '0;
                    par_bit_d  = 1'b0;
                    stop_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (dec_s && maj_s) begin
                    state_d = S_IDLE;
                end else if (bit_end_s) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (dec_s && (bit_idx_q == 4'(i))) begin
                        rx_buf_d[i] = maj_s;
                    end else begin
                        rx_buf_d[i] = rx_buf_q[i];
                    end
                end
                if (bit_end_s && (bit_idx_q == BIT_LAST)) begin
                    state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    bit_idx_d = '0;
                end else if (bit_end_s) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            S_PARITY: begin
                if (dec_s) begin
                    par_bit_d = maj_s;
                end else if (bit_end_s) begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (dec_s && (bit_idx_q == STOP_LAST)) begin
                    complete_s = 1'b1;
                end else if (dec_s) begin
                    stop_err_d = stop_err_q | ~maj_s;
                end else if (bit_end_s) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            S_BRK: begin
                state_d = s_s ? S_IDLE : S_BRK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (hs_s) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
            ovr_d   = ovr_q;
        end

        // A load in the handshake cycle keeps valid high with the new word.
        if (complete_s) begin
            pe_d    = pe_c_s;
            fe_d    = fe_c_s;
            brk_d   = brk_c_s;
            state_d = brk_c_s ? S_BRK : S_IDLE;
            if (fe_c_s) begin
                rx_data_d = rx_data_q;
            end else if (!valid_q || rx_if.rx_ready) begin
                rx_data_d = rx_buf_q;
                valid_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            pe_d  = pe_q;
            fe_d  = fe_q;
            brk_d = brk_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchroniser, counters, assembly buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            vote_q     <= 2'b00;
            rx_buf_q   <= '0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_line_i};
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            vote_q     <= vote_d;
            rx_buf_q   <= rx_buf_d;
            par_bit_q  <= par_bit_d;
            stop_err_q <= stop_err_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.valid      = valid_q;
    assign rx_if.busy       = busy_q;
    assign rx_if.parity_err = pe_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.break_det  = brk_q;
    assign rx_if.overrun    = ovr_q;

endmodule
